// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: op field layout, size codes,
// exception codes and FSM state encoding.
package mem_pkg;

    localparam int OP_STORE_BIT  = 3;
    localparam int OP_SIGNED_BIT = 2;
    localparam int OP_SIZE_LSB   = 0;

    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;

    localparam logic [1:0] EXC_NONE      = 2'd0;
    localparam logic [1:0] EXC_UNALIGNED = 2'd1;
    localparam logic [1:0] EXC_TIMEOUT   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_HOLD
    } state_t;

    // A dword access is only legal when the data path is 64 bits wide.
    function automatic logic is_unaligned(input logic [1:0] size,
                                          input logic [2:0] addr_lo,
                                          input logic       wide);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return |addr_lo[1:0];
            default:   return !wide || (|addr_lo);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering for a data-memory access: byte enables, store-data
// replication and load extract with sign/zero extension.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(NB)
) (
    input  logic [1:0]        size,
    input  logic              is_signed,
    input  logic [OFF_W-1:0]  offset,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [NB-1:0]     be,
    output logic [DATA_W-1:0] wdata_rep,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [3:0]        nbytes;
    logic [NB-1:0]     lane_mask;
    logic [DATA_W-1:0] data_mask;
    logic [DATA_W-1:0] shifted;
    logic              sign_bit;

    always_comb begin
        case (size)
            SIZE_BYTE: nbytes = 4'd1;
            SIZE_HALF: nbytes = 4'd2;
            SIZE_WORD: nbytes = 4'd4;
            default:   nbytes = 4'd8;
        endcase
        // Oversized requests are rejected upstream; clamp so indexing stays in range.
        if (int'(nbytes) > NB) begin
            nbytes = 4'(NB);
        end

        lane_mask = '0;
        data_mask = '0;
        for (int i = 0; i < NB; i++) begin
            lane_mask[i]       = (i < int'(nbytes));
            data_mask[8*i +: 8] = {8{i < int'(nbytes)}};
        end
        be = lane_mask << offset;

        shifted  = rdata >> {offset, 3'b000};
        sign_bit = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (int'(nbytes) == i + 1) begin
                sign_bit = shifted[8*i+7];
            end
        end
        rdata_ext = (shifted & data_mask) | ({DATA_W{is_signed & sign_bit}} & ~data_mask);

        wdata_rep = '0;
        for (int i = 0; i < NB; i++) begin
            wdata_rep[8*i +: 8] = wdata[8*(i & (int'(nbytes) - 1)) +: 8];
        end
    end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with valid/ready handshakes on both sides and a
// variable-latency req/ack data-memory bus with timeout.
module mem_stage_hs
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic [31:0]           in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_W-1:0]     out_addr,
    output logic [DATA_W-1:0]     out_rdata,
    output logic [31:0]           out_tag,
    output logic [1:0]            out_exc,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W/8-1:0]   bus_be,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_W-1:0]     bus_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    state_t            state;
    logic [3:0]        op_q;
    logic [TO_W-1:0]   to_cnt;

    logic              accept;
    logic              pass_op;
    logic              bad_align;
    logic [1:0]        align_size;
    logic              align_signed;
    logic [OFF_W-1:0]  align_off;
    logic [NB-1:0]     be_c;
    logic [DATA_W-1:0] wrep_c;
    logic [DATA_W-1:0] load_c;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_HOLD);
    assign bus_req   = (state == ST_BUS);
    assign pass_op   = (in_op == 4'd0);
    assign bad_align = is_unaligned(in_op[OP_SIZE_LSB +: 2], in_addr[2:0], DATA_W == 64);

    // The aligner serves the incoming op at issue and the latched op during BUS.
    assign align_size   = (state == ST_BUS) ? op_q[OP_SIZE_LSB +: 2] : in_op[OP_SIZE_LSB +: 2];
    assign align_signed = (state == ST_BUS) ? op_q[OP_SIGNED_BIT]    : in_op[OP_SIGNED_BIT];
    assign align_off    = (state == ST_BUS) ? out_addr[OFF_W-1:0]    : in_addr[OFF_W-1:0];

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size      (align_size),
        .is_signed (align_signed),
        .offset    (align_off),
        .wdata     (in_wdata),
        .rdata     (bus_rdata),
        .be        (be_c),
        .wdata_rep (wrep_c),
        .rdata_ext (load_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            to_cnt    <= '0;
            out_addr  <= '0;
            out_rdata <= '0;
            out_tag   <= '0;
            out_exc   <= EXC_NONE;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            case (state)
                ST_BUS: begin
                    // An ack on the final allowed cycle still completes normally.
                    if (bus_ack || (to_cnt == TO_W'(TIMEOUT - 1))) begin
                        state     <= ST_HOLD;
                        out_exc   <= bus_ack ? EXC_NONE : EXC_TIMEOUT;
                        out_rdata <= (bus_ack && !op_q[OP_STORE_BIT]) ? load_c : '0;
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_be    <= '0;
                        bus_wdata <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        op_q      <= in_op;
                        out_addr  <= in_addr;
                        out_tag   <= in_tag;
                        out_rdata <= '0;
                        to_cnt    <= '0;
                        if (pass_op || bad_align) begin
                            state   <= ST_HOLD;
                            out_exc <= pass_op ? EXC_NONE : EXC_UNALIGNED;
                        end else begin
                            state     <= ST_BUS;
                            out_exc   <= EXC_NONE;
                            bus_we    <= in_op[OP_STORE_BIT];
                            bus_addr  <= in_addr & ~ADDR_W'(NB - 1);
                            bus_be    <= be_c;
                            bus_wdata <= wrep_c;
                        end
                    end else if ((state == ST_HOLD) && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Self-checking bench for mem_stage_hs: directed vector table, hand-written
// handshake/reset sequences and randomized ops against a reference model.
module tb_mem_stage_hs;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [31:0] in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_rdata;
    logic [31:0] out_tag;
    logic [1:0]  out_exc;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_c;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_exc;
        int          exp_bus;
    } vec_t;

    vec_t tbl[15];

    mem_stage_hs #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TIMEOUT),
        .TO_W    (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_rdata (out_rdata),
        .out_tag   (out_tag),
        .out_exc   (out_exc),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Reference model: derived from access size and byte offset with plain arithmetic.
    function automatic vec_t predict(vec_t v);
        vec_t            r;
        int              nbytes;
        int              off;
        longint unsigned mask;
        longint unsigned val;
        r      = v;
        nbytes = 1 << v.op[1:0];
        off    = int'(v.addr % 4);
        r.exp_we    = v.op[3];
        r.exp_be    = 4'(((1 << nbytes) - 1) << off);
        r.exp_wdata = '0;
        for (int b = 0; b < 4; b++) begin
            r.exp_wdata[8*b +: 8] = v.wdata[8*(b % nbytes) +: 8];
        end
        r.exp_rdata = '0;
        r.exp_exc   = 2'd0;
        r.exp_bus   = 0;
        if (v.op == 4'd0) begin
            r.exp_exc = 2'd0;
        end else if (nbytes > 4 || (v.addr % nbytes) != 0) begin
            r.exp_exc = 2'd1;
        end else if (v.wait_c >= TIMEOUT) begin
            r.exp_exc = 2'd2;
            r.exp_bus = TIMEOUT;
        end else begin
            r.exp_bus = v.wait_c + 1;
            if (!v.op[3]) begin
                mask = (64'd1 << (8 * nbytes)) - 64'd1;
                val  = (64'(v.rdata) >> (8 * off)) & mask;
                if (v.op[2] && val[8*nbytes-1]) begin
                    val = val | ~mask;
                end
                r.exp_rdata = val[31:0];
            end
        end
        return r;
    endfunction

    // Issues one op with out_ready high, acks after wait_c bus cycles, and checks the result.
    task automatic applyStimulus(input vec_t v);
        logic [31:0] tag;
        int          nbus;
        bit          done;
        tag      = $urandom;
        in_valid = 1'b1;
        in_op    = v.op;
        in_addr  = v.addr;
        in_wdata = v.wdata;
        in_tag   = tag;
        checkOutput({v.name, " in_ready_idle"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = 4'($urandom);
        in_addr  = $urandom;
        nbus     = 0;
        done     = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (out_valid) begin
                done = 1'b1;
            end else begin
                if (bus_req) begin
                    checkOutput({v.name, " bus_we"}, 64'(bus_we), 64'(v.exp_we));
                    checkOutput({v.name, " bus_addr"}, 64'(bus_addr), 64'(v.addr & 32'hFFFF_FFFC));
                    checkOutput({v.name, " bus_be"}, 64'(bus_be), 64'(v.exp_be));
                    checkOutput({v.name, " bus_wdata"}, 64'(bus_wdata), 64'(v.exp_wdata));
                    checkOutput({v.name, " in_ready_bus"}, 64'(in_ready), 64'd0);
                    if (nbus == v.wait_c) begin
                        bus_ack   = 1'b1;
                        bus_rdata = v.rdata;
                    end
                    nbus++;
                end
                @(posedge clk); #1;
                bus_ack   = 1'b0;
                bus_rdata = $urandom;
            end
        end
        checkOutput({v.name, " out_valid"}, 64'(out_valid), 64'd1);
        checkOutput({v.name, " bus_cycles"}, 64'(nbus), 64'(v.exp_bus));
        checkOutput({v.name, " out_rdata"}, 64'(out_rdata), 64'(v.exp_rdata));
        checkOutput({v.name, " out_exc"}, 64'(out_exc), 64'(v.exp_exc));
        checkOutput({v.name, " out_addr"}, 64'(out_addr), 64'(v.addr));
        checkOutput({v.name, " out_tag"}, 64'(out_tag), 64'(tag));
        checkOutput({v.name, " bus_req_after"}, 64'(bus_req), 64'd0);
        @(posedge clk); #1;
        checkOutput({v.name, " out_valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        vec_t rv;

        // lbu would encode as in_op==0 (pass-through), so zero-extension is covered by lhu.
        tbl[0]  = '{"lw_wait3",   4'b0010, 32'h10, 32'h0,         32'hDEADBEEF, 3,  1'b0, 4'b1111, 32'h0,         32'hDEADBEEF, 2'd0, 4};
        tbl[1]  = '{"lb_s_13",    4'b0100, 32'h13, 32'h0,         32'h80AABBCC, 0,  1'b0, 4'b1000, 32'h0,         32'hFFFFFF80, 2'd0, 1};
        tbl[2]  = '{"lh_s_12",    4'b0101, 32'h12, 32'h0,         32'h80AABBCC, 1,  1'b0, 4'b1100, 32'h0,         32'hFFFF80AA, 2'd0, 2};
        tbl[3]  = '{"lhu_12",     4'b0001, 32'h12, 32'h0,         32'h80AABBCC, 0,  1'b0, 4'b1100, 32'h0,         32'h000080AA, 2'd0, 1};
        tbl[4]  = '{"lb_s_11",    4'b0100, 32'h11, 32'h0,         32'h80AABBCC, 0,  1'b0, 4'b0010, 32'h0,         32'hFFFFFFBB, 2'd0, 1};
        tbl[5]  = '{"sh_2",       4'b1001, 32'h2,  32'h1234ABCD,  32'h0,        2,  1'b1, 4'b1100, 32'hABCDABCD,  32'h0,        2'd0, 3};
        tbl[6]  = '{"sb_1",       4'b1000, 32'h1,  32'h00000055,  32'h0,        0,  1'b1, 4'b0010, 32'h55555555,  32'h0,        2'd0, 1};
        tbl[7]  = '{"sw_8",       4'b1010, 32'h8,  32'hCAFEF00D,  32'hFFFFFFFF, 0,  1'b1, 4'b1111, 32'hCAFEF00D,  32'h0,        2'd0, 1};
        tbl[8]  = '{"lw_unal_6",  4'b0010, 32'h6,  32'h0,         32'h0,        0,  1'b0, 4'b0000, 32'h0,         32'h0,        2'd1, 0};
        tbl[9]  = '{"lw_tmo",     4'b0010, 32'h20, 32'h0,         32'h12345678, 99, 1'b0, 4'b1111, 32'h0,         32'h0,        2'd2, 4};
        tbl[10] = '{"passthru",   4'b0000, 32'h7,  32'hFFFFFFFF,  32'h0,        0,  1'b0, 4'b0000, 32'h0,         32'h0,        2'd0, 0};
        tbl[11] = '{"ld_on_32",   4'b0011, 32'h8,  32'h0,         32'h0,        0,  1'b0, 4'b0000, 32'h0,         32'h0,        2'd1, 0};
        tbl[12] = '{"lh_unal_1",  4'b0001, 32'h1,  32'h0,         32'h0,        0,  1'b0, 4'b0000, 32'h0,         32'h0,        2'd1, 0};
        tbl[13] = '{"sw_tmo",     4'b1010, 32'h30, 32'h00000001,  32'h0,        99, 1'b1, 4'b1111, 32'h00000001,  32'h0,        2'd2, 4};
        tbl[14] = '{"lw_wait2",   4'b0110, 32'h44, 32'h0,         32'h0BADF00D, 2,  1'b0, 4'b1111, 32'h0,         32'h0BADF00D, 2'd0, 3};

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_addr   = '0;
        in_wdata  = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst bus_req", 64'(bus_req), 64'd0);
        checkOutput("rst out_exc", 64'(out_exc), 64'd0);
        checkOutput("rst out_rdata", 64'(out_rdata), 64'd0);
        checkOutput("rst bus_be", 64'(bus_be), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i]);
        end

        // Back-to-back ops while MEM/WB stalls for three cycles.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 4'b0000;
        in_addr   = 32'h100;
        in_tag    = 32'hA1;
        @(posedge clk); #1;
        in_op    = 4'b0010;
        in_addr  = 32'h200;
        in_tag   = 32'hB2;
        for (int c = 0; c < 3; c++) begin
            checkOutput("stall out_valid", 64'(out_valid), 64'd1);
            checkOutput("stall in_ready", 64'(in_ready), 64'd0);
            checkOutput("stall out_tag", 64'(out_tag), 64'hA1);
            checkOutput("stall out_addr", 64'(out_addr), 64'h100);
            checkOutput("stall bus_req", 64'(bus_req), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checkOutput("release in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("b2b out_valid_gap", 64'(out_valid), 64'd0);
        checkOutput("b2b bus_req", 64'(bus_req), 64'd1);
        checkOutput("b2b bus_addr", 64'(bus_addr), 64'h200);
        bus_ack   = 1'b1;
        bus_rdata = 32'h11223344;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        checkOutput("b2b out_valid", 64'(out_valid), 64'd1);
        checkOutput("b2b out_tag", 64'(out_tag), 64'hB2);
        checkOutput("b2b out_rdata", 64'(out_rdata), 64'h11223344);
        @(posedge clk); #1;
        checkOutput("b2b no_dup", 64'(out_valid), 64'd0);

        // Reset during the second BUS cycle, then a stray late ack.
        in_valid = 1'b1;
        in_op    = 4'b0010;
        in_addr  = 32'h40;
        in_tag   = 32'hC3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("rstbus bus_req_c1", 64'(bus_req), 64'd1);
        @(posedge clk); #1;
        checkOutput("rstbus bus_req_c2", 64'(bus_req), 64'd1);
        reset = 1'b0;
        #1;
        checkOutput("rstbus bus_req_drop", 64'(bus_req), 64'd0);
        checkOutput("rstbus out_valid", 64'(out_valid), 64'd0);
        checkOutput("rstbus in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        reset     = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 32'hFEEDFACE;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        checkOutput("lateack out_valid", 64'(out_valid), 64'd0);
        checkOutput("lateack bus_req", 64'(bus_req), 64'd0);
        checkOutput("lateack in_ready", 64'(in_ready), 64'd1);
        checkOutput("lateack out_rdata", 64'(out_rdata), 64'd0);

        for (int n = 0; n < 150; n++) begin
            rv.name   = "rand";
            rv.op     = 4'($urandom_range(0, 15));
            rv.addr   = $urandom;
            rv.wdata  = $urandom;
            rv.rdata  = $urandom;
            rv.wait_c = int'($urandom_range(0, 5));
            rv = predict(rv);
            applyStimulus(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Next-generation MEM pipeline stage with a parametrised data path and a variable-latency data-memory bus, replacing the fixed single-cycle DM.
- Accepts one decoded memory operation per transaction from EX/MEM.
- Checks alignment and drives a req/ack memory bus.
- Aligns and extends load data, then hands results to MEM/WB.
- Stalls upstream through a valid/ready handshake.
- Raises unaligned and bus-timeout exceptions.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; must be 32 or 64.
- TIMEOUT, 255, maximum bus wait cycles before a timeout exception. Must be at least 1.
- TO_W, 8, counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  EX/MEM holds an operation
- in_ready  out  1  stage can accept an operation
- in_op  in  4  {is_store, is_signed, size[1:0]}, size 0=byte, 1=half, 2=word, 3=dword. in_op==0 is a non-memory pass-through.
- in_addr  in  ADDR_W  effective address (AO)
- in_wdata  in  DATA_W  store data (rt)
- in_tag  in  32  instruction word, passed through unchanged
- out_valid  out  1  result ready for MEM/WB
- out_ready  in  1  MEM/WB accepts the result
- out_addr  out  ADDR_W  registered in_addr
- out_rdata  out  DATA_W  aligned and extended load data (MO); 0 for stores and pass-through
- out_tag  out  32  registered in_tag
- out_exc  out  2  0=none, 1=unaligned, 2=bus timeout
- bus_req  out  1  memory request
- bus_we  out  1  write
- bus_addr  out  ADDR_W  in_addr with the low log2(DATA_W/8) bits cleared
- bus_be  out  DATA_W/8  byte enables
- bus_wdata  out  DATA_W  store data replicated into lane position
- bus_ack  in  1  request completed; read data valid in the same cycle
- bus_rdata  in  DATA_W  read data

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; all outputs 0, except in_ready which is 1.
  - A reset mid-bus-transaction drops bus_req immediately and discards the operation.
- State machine IDLE, BUS, HOLD:
  - IDLE: in_ready=1. On in_valid, latch op, addr, wdata and tag.
    - Pass-through op or unaligned op: go to HOLD next cycle. No bus activity for either.
    - Otherwise go to BUS with bus_req=1 in the following cycle.
  - BUS: bus_req=1; bus_we, bus_addr, bus_be and bus_wdata stay stable until ack. in_ready=0.
    - Cycle with bus_ack=1: capture rdata, go to HOLD.
    - Timeout counter starts at 0 on entry and increments each non-ack cycle. When it reaches TIMEOUT without ack: out_exc=2, go to HOLD, bus_req drops.
    - If bus_ack and the timeout coincide, ack wins.
  - HOLD: out_valid=1; in_ready = out_ready. While out_valid=1 and out_ready=0, all out_* stay frozen.
    - If out_ready and in_valid: accept the next operation in the same cycle, as in IDLE.
    - If out_ready only: go to IDLE.
- Latency: minimum 2 cycles from acceptance to out_valid for a bus op with ack in the first BUS cycle; 1 cycle for pass-through or exception ops.
- Alignment rule: unaligned when addr mod 2^size != 0. size=3 with DATA_W=32 is also treated as unaligned.
- Byte enables: bus_be = ((1<<2^size)-1) << (addr mod DATA_W/8).
- Loads: the selected lanes are shifted down to bit 0, then sign-extended if is_signed, else zero-extended.
- Stores: bus_wdata is in_wdata's low 2^size bytes replicated across all lanes.
- Exception ops produce out_rdata=0 and never assert bus_req.
- A bus_ack while not in BUS is ignored.

Decomposition:
- Shared package mem_pkg holds:
  - op field positions;
  - size codes;
  - exception codes EXC_NONE, EXC_UNALIGNED, EXC_TIMEOUT;
  - state encoding.
- One natural sub-module, mem_lane_align (combinational), computes be, write replication and load extract/extend. It is reused by a future instruction-fetch stage.

Test Plan:
- lw at 0x0000_0010, bus_ack after 3 wait cycles with rdata 0xDEADBEEF -> bus_req high exactly 4 cycles, be=4'b1111; out_valid 1 cycle later; out_rdata=0xDEADBEEF; out_exc=0.
- lb signed at 0x13, rdata 0x80AA_BBCC -> be=4'b1000; out_rdata=0xFFFF_FF80. Same access with lbu -> 0x0000_0080.
- sh at 0x2, wdata 0x1234_ABCD -> bus_we=1, be=4'b1100, bus_wdata=0xABCD_ABCD; out_rdata=0.
- lw at 0x6 -> no bus_req; out_valid next cycle; out_exc=1. Then lw with TIMEOUT=4 and no ack -> out_exc=2 after 4 BUS cycles; bus_req low afterwards.
- Back-to-back ops with out_ready held low 3 cycles -> outputs frozen, in_ready=0. On release, the next op is accepted in the same cycle; no op is lost or duplicated.
- Reset asserted in the 2nd BUS cycle -> bus_req=0 within the same cycle; out_valid=0, in_ready=1. A late bus_ack after reset release is ignored.
